move_scheduler: RTL and testbench

Sequences player commands into the game-logic block. Buffers decoded key events from the keyboard front end, then issues each one to the logic's `move` input as a single-cycle pulse, enforcing a minimum spacing between moves. A RESET key takes priority over everything queued. Sits between the keyboard decoder and the game-logic module; it is the only driver of `move`.

---
 rtl/move_scheduler_pkg.sv | 29 ++
 rtl/move_scheduler_if.sv | 12 +
 rtl/move_fifo.sv | 76 +++++++
 rtl/move_scheduler.sv | 124 ++++++++++++
 tb/tb_move_scheduler.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/move_scheduler_pkg.sv
// Shared move-code definitions, scheduler states and small helpers.
// These codes are the same ones the game-logic block decodes.
package move_scheduler_pkg;

  localparam int unsigned MOVE_W = 3;

  typedef enum logic [MOVE_W-1:0] {
    MOVE_NONE    = 3'd0,
    MOVE_UP      = 3'd1,
    MOVE_DOWN    = 3'd2,
    MOVE_LEFT    = 3'd3,
    MOVE_RIGHT   = 3'd4,
    MOVE_PLAY    = 3'd5,
    MOVE_RESET   = 3'd6,
    MOVE_INVALID = 3'd7
  } move_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_COOL
  } sched_state_e;

  // Codes that occupy a queue slot (RESET bypasses the queue).
  function automatic logic is_storable(input logic [MOVE_W-1:0] code);
    return (code >= MOVE_UP) && (code <= MOVE_PLAY);
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Key-event handshake from the keyboard decoder into the scheduler.
interface move_scheduler_if;
  import move_scheduler_pkg::*;

  logic              key_valid;
  logic [MOVE_W-1:0] key_code;
  logic              key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);

endinterface

// File: rtl/move_fifo.sv
// DEPTH x W synchronous FIFO with flush; flush beats push on the same edge.
module move_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Queues key events and issues them to the game logic as one-cycle move
// pulses separated by a cooldown; RESET overrides anything queued.
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned COOLDOWN = 10_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  move_scheduler_if.slave        key,
  output logic [MOVE_W-1:0]      move,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN - 1);

  sched_state_e          state_q, state_d;
  logic [MOVE_W-1:0]     move_q, move_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [7:0]            drop_q, drop_d;

  logic                  reset_evt, storable, push, pop, drop;
  logic                  fifo_full, fifo_empty;
  logic [MOVE_W-1:0]     fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;

  assign reset_evt     = key.key_valid && (key.key_code == MOVE_RESET);
  assign storable      = key.key_valid && is_storable(key.key_code);
  assign push          = storable && !fifo_full;
  assign drop          = storable && fifo_full;
  // An arriving RESET suppresses the IDLE pop; the queue is flushed instead.
  assign pop           = (state_q == ST_IDLE) && !pend_q && !fifo_empty && !reset_evt;
  assign key.key_ready = !fifo_full;

  assign move     = move_q;
  assign drop_cnt = drop_q;
  assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);

  move_fifo #(
    .DEPTH (DEPTH),
    .W     (MOVE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (reset_evt),
    .din   (key.key_code),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Scheduler next-state: issue, cooldown, pending-reset and drop counting.
  always_comb begin
    state_d = state_q;
    move_d  = MOVE_NONE;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop_d  = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_ISSUE;
          move_d  = MOVE_RESET;
          pend_d  = 1'b0;
        end else if (pop) begin
          state_d = ST_ISSUE;
          move_d  = fifo_dout;
        end
      end
      ST_ISSUE: begin
        state_d = ST_COOL;
        cnt_d   = COOL_LOAD;
      end
      ST_COOL: begin
        if (cnt_q == '0) begin
          if (pend_q) begin
            state_d = ST_ISSUE;
            move_d  = MOVE_RESET;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reset_evt) begin
      pend_d = 1'b1;
    end

    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Scheduler registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      move_q  <= MOVE_NONE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      move_q  <= move_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: DUT1 uses DEPTH=4/COOLDOWN=3,
// DUT2 uses DEPTH=2/COOLDOWN=1000 to hold the queue full for drop saturation.
module tb_move_scheduler;
  import move_scheduler_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] mv1, mv2;
  logic       busy1, busy2;
  logic [7:0] drop1, drop2;
  int         tests;
  int         fails;

  move_scheduler_if k1 ();
  move_scheduler_if k2 ();

  move_scheduler #(.DEPTH(4), .COOLDOWN(3)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (k1),
    .move     (mv1),
    .busy     (busy1),
    .drop_cnt (drop1)
  );

  move_scheduler #(.DEPTH(2), .COOLDOWN(1000)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (k2),
    .move     (mv2),
    .busy     (busy2),
    .drop_cnt (drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic v, input logic [2:0] c);
    k1.key_valid = v;
    k1.key_code  = c;
  endtask

  task automatic drive2(input logic v, input logic [2:0] c);
    k2.key_valid = v;
    k2.key_code  = c;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive1(1'b0, MOVE_NONE);
    drive2(1'b0, MOVE_NONE);
    step();
    step();

    // Reset values
    check("rst_move", 32'(mv1), 32'(MOVE_NONE));
    check("rst_busy", 32'(busy1), 0);
    check("rst_ready", 32'(k1.key_ready), 1);
    check("rst_drop", 32'(drop1), 0);
    rst_n = 1'b1;

    // Single UP: pop at E1, move=UP for one cycle, 3 cooldown cycles, then IDLE
    drive1(1'b1, MOVE_UP);
    step();
    drive1(1'b0, MOVE_NONE);
    check("t1_e0_move", 32'(mv1), 32'(MOVE_NONE));
    check("t1_e0_busy", 32'(busy1), 1);
    step();
    check("t1_issue", 32'(mv1), 32'(MOVE_UP));
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_cool_move", 32'(mv1), 32'(MOVE_NONE));
      check("t1_cool_busy", 32'(busy1), 1);
    end
    step();
    check("t1_idle_busy", 32'(busy1), 0);
    check("t1_idle_move", 32'(mv1), 32'(MOVE_NONE));

    // NONE and code 7 are ignored
    drive1(1'b1, MOVE_NONE);
    step();
    drive1(1'b1, MOVE_INVALID);
    step();
    drive1(1'b0, MOVE_NONE);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ign_move", 32'(mv1), 32'(MOVE_NONE));
    end
    check("ign_busy", 32'(busy1), 0);
    check("ign_drop", 32'(drop1), 0);
    check("ign_ready", 32'(k1.key_ready), 1);

    // UP then LEFT,RIGHT,DOWN,PLAY back-to-back; drops at P5,P6,P8; RIGHT accepted at P7
    for (int k = 0; k <= 30; k++) begin
      case (k)
        0: drive1(1'b1, MOVE_UP);
        1: drive1(1'b1, MOVE_LEFT);
        2: drive1(1'b1, MOVE_RIGHT);
        3: drive1(1'b1, MOVE_DOWN);
        4: drive1(1'b1, MOVE_PLAY);
        5: drive1(1'b1, MOVE_UP);
        6: drive1(1'b1, MOVE_UP);
        7: drive1(1'b1, MOVE_RIGHT);
        8: drive1(1'b1, MOVE_UP);
        default: drive1(1'b0, MOVE_NONE);
      endcase
      step();
      case (k)
        1:  check("t2_move_up", 32'(mv1), 32'(MOVE_UP));
        6:  check("t2_move_left", 32'(mv1), 32'(MOVE_LEFT));
        11: check("t2_move_right", 32'(mv1), 32'(MOVE_RIGHT));
        16: check("t2_move_down", 32'(mv1), 32'(MOVE_DOWN));
        21: check("t2_move_play", 32'(mv1), 32'(MOVE_PLAY));
        26: check("t2_move_right2", 32'(mv1), 32'(MOVE_RIGHT));
        default: check("t2_move_none", 32'(mv1), 32'(MOVE_NONE));
      endcase
      if (k == 4) check("t2_ready_full", 32'(k1.key_ready), 0);
      if (k == 5) check("t2_drop1", 32'(drop1), 1);
      if (k == 7) check("t2_ready_refull", 32'(k1.key_ready), 0);
      if (k == 8) check("t2_drop3", 32'(drop1), 3);
    end
    check("t2_end_busy", 32'(busy1), 0);
    check("t2_end_drop", 32'(drop1), 3);

    // Three queued moves, RESET during COOL: queue flushed, RESET issued after COOL
    for (int k = 0; k <= 10; k++) begin
      case (k)
        0: drive1(1'b1, MOVE_UP);
        1: drive1(1'b1, MOVE_LEFT);
        2: drive1(1'b1, MOVE_RIGHT);
        3: drive1(1'b1, MOVE_DOWN);
        4: drive1(1'b1, MOVE_RESET);
        default: drive1(1'b0, MOVE_NONE);
      endcase
      step();
      case (k)
        1: check("t4_move_up", 32'(mv1), 32'(MOVE_UP));
        5: check("t4_move_reset", 32'(mv1), 32'(MOVE_RESET));
        default: check("t4_move_none", 32'(mv1), 32'(MOVE_NONE));
      endcase
      if (k == 3) check("t4_ready_3q", 32'(k1.key_ready), 1);
      if (k == 4) check("t4_busy_cool", 32'(busy1), 1);
    end
    check("t4_end_busy", 32'(busy1), 0);

    // RESET on the same edge an IDLE pop would occur: UP never issued
    for (int k = 0; k <= 7; k++) begin
      case (k)
        0: drive1(1'b1, MOVE_UP);
        1: drive1(1'b1, MOVE_RESET);
        default: drive1(1'b0, MOVE_NONE);
      endcase
      step();
      if (k == 2) check("t5_move_reset", 32'(mv1), 32'(MOVE_RESET));
      else        check("t5_move_none", 32'(mv1), 32'(MOVE_NONE));
    end
    check("t5_end_busy", 32'(busy1), 0);

    // rst_n asserted during ISSUE with a non-empty queue
    drive1(1'b1, MOVE_UP);
    step();
    drive1(1'b1, MOVE_LEFT);
    step();
    drive1(1'b0, MOVE_NONE);
    check("t6_issue", 32'(mv1), 32'(MOVE_UP));
    check("t6_busy_pre", 32'(busy1), 1);
    rst_n = 1'b0;
    step();
    check("t6_rst_move", 32'(mv1), 32'(MOVE_NONE));
    check("t6_rst_busy", 32'(busy1), 0);
    check("t6_rst_ready", 32'(k1.key_ready), 1);
    check("t6_rst_drop", 32'(drop1), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_after_move", 32'(mv1), 32'(MOVE_NONE));
    end

    // DUT2: fill a 2-deep queue during a long cooldown, then saturate drop_cnt
    drive2(1'b1, MOVE_UP);
    step();
    drive2(1'b1, MOVE_LEFT);
    step();
    check("d2_issue", 32'(mv2), 32'(MOVE_UP));
    drive2(1'b1, MOVE_RIGHT);
    step();
    check("d2_ready_full", 32'(k2.key_ready), 0);
    drive2(1'b1, MOVE_INVALID);
    step();
    drive2(1'b1, MOVE_NONE);
    step();
    check("d2_ign_full_drop", 32'(drop2), 0);
    drive2(1'b1, MOVE_DOWN);
    step();
    check("d2_drop1", 32'(drop2), 1);
    for (int i = 2; i <= 300; i++) begin
      step();
      if (i == 254) check("d2_drop254", 32'(drop2), 254);
      if (i == 255) check("d2_drop255", 32'(drop2), 255);
    end
    drive2(1'b0, MOVE_NONE);
    check("d2_drop_sat", 32'(drop2), 255);
    check("d2_move_cool", 32'(mv2), 32'(MOVE_NONE));
    check("d2_busy_cool", 32'(busy2), 1);
    rst_n = 1'b0;
    step();
    check("d2_rst_drop", 32'(drop2), 0);
    check("d2_rst_busy", 32'(busy2), 0);
    check("d2_rst_ready", 32'(k2.key_ready), 1);
    rst_n = 1'b1;
    step();
    check("d2_after_move", 32'(mv2), 32'(MOVE_NONE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
